// File: rtl/base_skid_pkg.sv
// Shared types and constants for the base_skid two-entry skid buffer.
package base_skid_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_BUSY  = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_t;

  localparam int unsigned STALLCNT_W = 32;

endpackage

// File: rtl/base_skid_stallcnt.sv
// Saturating stall-cycle counter for base_skid; only built when
// BASE_SKID_STALLCNT_EN is defined.
`ifdef BASE_SKID_STALLCNT_EN
module base_skid_stallcnt
  import base_skid_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [0:STALLCNT_W-1] cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/base_skid.sv
// Two-entry skid buffer with registered ready, valid and data.
// Optional stall counter port enabled by BASE_SKID_STALLCNT_EN.
module base_skid
  import base_skid_pkg::*;
#(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             i_r,
  input  logic             i_v,
  input  logic [0:width-1] i_d,
  input  logic             o_r,
  output logic             o_v,
  output logic [0:width-1] o_d
`ifdef BASE_SKID_STALLCNT_EN
  ,
  output logic [0:STALLCNT_W-1] stall_cnt
`endif
);

  skid_state_t      state_q, state_d;
  logic [0:width-1] skid_q;
  logic             in_xfer;
  logic             load_main, load_skid, main_from_skid;

  assign in_xfer = i_v && i_r;
  assign o_v     = (state_q != SKID_EMPTY);

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_d   = SKID_BUSY;
        end
      end
      SKID_BUSY: begin
        if (in_xfer && o_r) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = SKID_FULL;
        end else if (o_r) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (o_r) begin
          main_from_skid = 1'b1;
          state_d        = SKID_BUSY;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Ready is registered: it looks ahead at the next state so that o_r
  // never reaches i_r combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SKID_EMPTY;
      i_r     <= 1'b0;
    end else begin
      state_q <= state_d;
      i_r     <= (state_d != SKID_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (load_main) begin
      o_d <= i_d;
    end else if (main_from_skid) begin
      o_d <= skid_q;
    end
    if (load_skid) begin
      skid_q <= i_d;
    end
  end

`ifdef BASE_SKID_STALLCNT_EN
  base_skid_stallcnt u_stallcnt (
    .clk   (clk),
    .reset (reset),
    .inc   (o_v && !o_r),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_base_skid.sv
// Randomized/directed bench for base_skid (width=8) against a queue model
// of a two-deep FIFO with registered ready.
module tb_base_skid;
  import base_skid_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_r, i_v = 1'b0, o_r = 1'b0, o_v;
  logic [0:7] i_d = '0, o_d;
`ifdef BASE_SKID_STALLCNT_EN
  logic [0:STALLCNT_W-1] stall_cnt;
  logic [31:0]           exp_sc = '0;
`endif

  int          total = 0;
  int          bad = 0;
  int          n_in = 0;
  logic [7:0]  q[$];
  logic        exp_ir = 1'b0;

  always #5 clk = ~clk;

  base_skid #(.width(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .i_r   (i_r),
    .i_v   (i_v),
    .i_d   (i_d),
    .o_r   (o_r),
    .o_v   (o_v),
    .o_d   (o_d)
`ifdef BASE_SKID_STALLCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge: update the model from the pre-edge inputs, then check.
  task automatic tick();
    logic had_v;
    @(posedge clk);
    had_v = (q.size() > 0);
    if (!reset) begin
      q.delete();
      exp_ir = 1'b0;
`ifdef BASE_SKID_STALLCNT_EN
      exp_sc = '0;
`endif
    end else begin
`ifdef BASE_SKID_STALLCNT_EN
      if (had_v && !o_r && exp_sc != 32'hFFFFFFFF) exp_sc++;
`endif
      if (had_v && o_r) void'(q.pop_front());
      if (i_v && exp_ir) begin
        q.push_back(i_d);
        n_in++;
      end
      exp_ir = (q.size() < 2);
    end
    #1;
    chk("o_v", {31'd0, o_v}, {31'd0, q.size() > 0});
    chk("i_r", {31'd0, i_r}, {31'd0, exp_ir});
    if (q.size() > 0) chk("o_d", {24'd0, o_d}, {24'd0, q[0]});
`ifdef BASE_SKID_STALLCNT_EN
    chk("stall_cnt", stall_cnt, exp_sc);
`endif
  endtask

  initial begin
    // Reset held with a valid word offered; it must never be taken.
    reset = 1'b0; i_v = 1'b1; i_d = 8'hAA; o_r = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rel_ir1", {31'd0, i_r}, 32'd1);
    i_v = 1'b0;
    tick();
    chk("rel_no_aa", {31'd0, o_v}, 32'd0);

    // Back-to-back streaming.
    o_r = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_v = 1'b1; i_d = 8'(k);
      tick();
      chk("stream_ir", {31'd0, i_r}, 32'd1);
      chk("stream_od", {24'd0, o_d}, k);
    end
    i_v = 1'b0;
    tick();

    // Skid fill and drain.
    o_r = 1'b0; i_v = 1'b1; i_d = 8'h11;
    tick();
    i_d = 8'h22;
    tick();
    chk("skid_ir0", {31'd0, i_r}, 32'd0);
    i_v = 1'b0;
    tick();
    o_r = 1'b1;
    tick();
    chk("skid_22", {24'd0, o_d}, 32'h22);
    chk("skid_ir1", {31'd0, i_r}, 32'd1);
    tick();
    chk("skid_empty", {31'd0, o_v}, 32'd0);

    // Random traffic with backpressure.
    n_in = 0;
    for (int cyc = 0; cyc < 20000 && n_in < 1000; cyc++) begin
      i_v = 1'($urandom_range(0, 1));
      o_r = 1'($urandom_range(0, 1));
      i_d = 8'($urandom);
      tick();
    end
    chk("rand_count", n_in, 1000);
    i_v = 1'b0; o_r = 1'b1;
    repeat (3) tick();
    chk("rand_drain", q.size(), 0);

    // Reset while FULL discards both words.
    o_r = 1'b0; i_v = 1'b1; i_d = 8'h33;
    tick();
    i_d = 8'h44;
    tick();
    chk("full_33", {24'd0, o_d}, 32'h33);
    i_v = 1'b0; reset = 1'b0; o_r = 1'b1;
    tick();
    chk("mid_rst_ov", {31'd0, o_v}, 32'd0);
    reset = 1'b1;
    repeat (4) tick();

`ifdef BASE_SKID_STALLCNT_EN
    o_r = 1'b0; i_v = 1'b1; i_d = 8'h55;
    tick();
    i_v = 1'b0;
    repeat (7) tick();
    chk("stall7", stall_cnt, 32'd7);
    force u_dut.u_stallcnt.cnt = 32'hFFFFFFFE;
    #1;
    release u_dut.u_stallcnt.cnt;
    exp_sc = 32'hFFFFFFFE;
    repeat (3) tick();
    chk("stall_sat", stall_cnt, 32'hFFFFFFFF);
    o_r = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
